// File: rtl/onehot_decoder_scan.sv
// Binary-to-one-hot decoder with registered valid/ready output stage and an
// autonomous scan mode that sweeps every index with a programmable hold time.
module onehot_decoder_scan #(
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned HOLD_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_en,
  input  logic [HOLD_W-1:0]     hold_cycles,
  input  logic                  scan_start,
  input  logic                  scan_stop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<SEL_W)-1:0] out_onehot,
  output logic [SEL_W-1:0]      out_idx,
  output logic                  busy,
  output logic                  wrap
);

  localparam int unsigned OUT_W = 1 << SEL_W;
  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(OUT_W - 1);
  localparam logic [HOLD_W-1:0] ONE_H    = HOLD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [OUT_W-1:0]    onehot_q, onehot_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                wrap_q, wrap_d;
  logic                stop_q, stop_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;

  logic                accept;
  logic                out_hs;
  logic                start_ok;
  logic                stop_now;
  logic                hold_last;
  logic [HOLD_W-1:0]   hold_eff;
  logic [SEL_W-1:0]    idx_nxt;

  function automatic logic [OUT_W-1:0] onehot_of(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] w;
    w      = '0;
    w[sel] = 1'b1;
    return w;
  endfunction

  // A zero hold request is treated as a one-cycle hold
  assign hold_eff  = (hold_cycles == '0) ? ONE_H : hold_cycles;
  assign in_ready  = (state_q == S_IDLE) && !mode && (!valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = valid_q && out_ready;
  assign start_ok  = (state_q == S_IDLE) && mode && scan_start && !valid_q;
  assign stop_now  = stop_q || scan_stop;
  assign hold_last = (cnt_q <= ONE_H);
  assign idx_nxt   = idx_q + SEL_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = (hold_eff == ONE_H) ? S_PRESENT : S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_last) begin
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_hs) begin
          if (stop_now) begin
            state_d = S_IDLE;
          end else if (hold_q != ONE_H) begin
            state_d = S_HOLD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    valid_d  = valid_q;
    onehot_d = onehot_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    wrap_d   = 1'b0;
    stop_d   = stop_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          valid_d  = 1'b1;
          onehot_d = in_en ? onehot_of(in_sel) : '0;
          idx_d    = in_sel;
        end else if (out_hs) begin
          valid_d = 1'b0;
        end
        if (start_ok) begin
          hold_d   = hold_eff;
          cnt_d    = hold_eff - ONE_H;
          idx_d    = '0;
          onehot_d = onehot_of(SEL_W'(0));
          busy_d   = 1'b1;
          stop_d   = 1'b0;
          valid_d  = (hold_eff == ONE_H);
        end
      end
      S_HOLD: begin
        if (scan_stop) begin
          stop_d = 1'b1;
        end
        if (hold_last) begin
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE_H;
        end
      end
      S_PRESENT: begin
        if (scan_stop) begin
          stop_d = 1'b1;
        end
        if (out_hs) begin
          if (stop_now) begin
            valid_d  = 1'b0;
            onehot_d = '0;
            busy_d   = 1'b0;
            stop_d   = 1'b0;
          end else begin
            idx_d    = idx_nxt;
            onehot_d = onehot_of(idx_nxt);
            wrap_d   = (idx_q == LAST_IDX);
            cnt_d    = hold_q - ONE_H;
            valid_d  = (hold_q == ONE_H);
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        stop_d  = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      onehot_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
      stop_q   <= 1'b0;
      hold_q   <= ONE_H;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
      stop_q   <= stop_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_onehot = onehot_q;
  assign out_idx    = idx_q;
  assign busy       = busy_q;
  assign wrap       = wrap_q;

  // Structural invariants of the decoder and sweep controller
  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(onehot_q));
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready |-> (state_q == S_IDLE));
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (state_q != S_IDLE));

endmodule

// File: doc/onehot_decoder_scan.md
Name: onehot_decoder_scan

Overview:
- Parametrised binary-to-one-hot decoder with a registered output stage and a valid/ready handshake.
- Adds an autonomous scan mode that steps through every output index with a programmable per-index hold time.
- Drives chip-select and row-select strobes from either a host index stream or a free-running sweep.

Parameters:
SEL_W, 3, index width; output width OUT_W = 2**SEL_W (derived, not overridable)
HOLD_W, 8, width of the hold-time field

Ports:
clk  input  1  clock; all logic rising-edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = decode, 1 = scan; sampled only in IDLE
in_valid  input  1  decode request valid
in_ready  output  1  decode request accepted when in_valid && in_ready
in_sel  input  SEL_W  index to decode
in_en  input  1  0 = emit all-zero word for this request
hold_cycles  input  HOLD_W  scan hold per index; latched at scan start
scan_start  input  1  start sweep
scan_stop  input  1  request sweep end
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_onehot  output  OUT_W  decoded word
out_idx  output  SEL_W  index that out_onehot represents
busy  output  1  high while scanning
wrap  output  1  one-cycle pulse on sweep wrap

Behaviour:
Reset and reset mid-operation:
- rst_n low asynchronously clears out_valid, out_onehot, out_idx, busy, wrap, the hold counter and the stop flag.
- The FSM returns to IDLE.
- This applies at any point, including mid-scan.

Decoding rule:
- Every index 0..OUT_W-1 decodes to exactly bit[idx].
- No index is reserved or maps to zero.

Decode mode (IDLE, mode=0):
- in_ready = !out_valid || out_ready, combinational.
- On accept: out_onehot <= in_en ? (1 << in_sel) : 0; out_idx <= in_sel; out_valid <= 1. Latency is 1 cycle.
- Accept and handshake in the same cycle is allowed, giving 1 beat/cycle throughput.
- Handshake with no new accept: out_valid <= 0; out_onehot and out_idx hold their last value.
- While out_valid && !out_ready, out_onehot and out_idx are stable.

Scan mode:
- in_ready = 0 whenever mode=1 or the FSM is not in IDLE.
- FSM states: IDLE, HOLD, PRESENT.
- IDLE -> HOLD: on scan_start && mode && !out_valid; otherwise scan_start is ignored. On this transition:
  - latch H = (hold_cycles == 0) ? 1 : hold_cycles;
  - idx = 0, out_onehot = 1 << 0;
  - counter = H-1, busy = 1.
- HOLD: counter decrements each cycle; out_valid = 0; out_onehot is driven. At counter == 0, go to PRESENT.
  - If H = 1, skip HOLD and enter PRESENT directly.
- PRESENT: out_valid = 1. On handshake:
  - if stop flag set: IDLE; out_onehot <= 0, out_valid <= 0, busy <= 0, stop flag cleared;
  - else: idx <= idx+1 (mod OUT_W), out_onehot follows, counter reloads H-1, go to HOLD (or stay in PRESENT if H = 1).
- Each index is therefore driven for at least H cycles, with out_valid high only in the final cycle(s).
- Wrap:
  - The handshake of idx = OUT_W-1 while continuing pulses wrap for 1 cycle and idx returns to 0.
  - No wrap pulse when stopping.
- scan_stop: a pulse in HOLD or PRESENT sets a sticky stop flag. The sweep always completes the current beat; no mid-beat truncation.
- scan_stop && handshake in the same cycle: treated as a stop for that handshake.
- scan_stop in IDLE: ignored.
- mode changes outside IDLE: ignored until IDLE.
- hold_cycles changes mid-scan: no effect.
- Full-scale hold: H = 2**HOLD_W - 1; the counter never overflows.

Test Plan:
- SEL_W=3, out_ready=1, in_en=1, in_sel 0..7 on consecutive cycles -> out_onehot 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80 one cycle after each; out_idx matches; in_ready never drops.
- Accept sel=5, then out_ready=0 for 4 cycles with in_valid sel=2 -> in_ready=0, out_onehot=0x20 stable; release out_ready -> 0x04 appears the next cycle.
- in_en=0, in_sel=6 -> out_valid=1, out_onehot=0x00, out_idx=6.
- mode=1, hold_cycles=3, scan_start, out_ready=1 -> each index drives 3 cycles with out_valid in the 3rd; wrap pulses after idx 7's handshake; 24-cycle period; in_ready=0 throughout.
- hold_cycles=0 -> one index per cycle. Then scan_stop at idx 4 with out_ready=0 for 5 cycles -> idx 4 held until handshake, then out_onehot=0, busy=0, no wrap.
- rst_n low while scanning idx 5 -> out_onehot, out_valid, busy and wrap go 0 without a clock edge; after release, a decode request works normally.
